// File: rtl/snn_pkg.sv
// Shared SNN definitions: timestamp type, axon FSM states and the wrap-safe
// due-time test (also used by the soma refractory logic).
package snn_pkg;

    localparam int SNN_TS_W = 8;

    typedef logic [SNN_TS_W-1:0] spike_ts_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_EMIT = 2'd2
    } axon_state_t;

    // A timestamp is due once it lies no more than half the timestamp range behind now.
    function automatic logic ts_is_due(input spike_ts_t now, input spike_ts_t due);
        spike_ts_t age;
        age = now - due;
        return ~age[SNN_TS_W-1];
    endfunction

endpackage

// File: rtl/spike_fifo.sv
// In-order register FIFO of spike due-times with flush and same-cycle push+pop
// when full; exposes the head and the entry behind it.
module spike_fifo #(
    parameter int TS_W  = 8,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [TS_W-1:0]  push_ts,
    output logic [TS_W-1:0]  head_ts,
    output logic [TS_W-1:0]  next_ts,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [TS_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_nxt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_nxt  = rd_ptr + PTR_W'(1);
    assign head_ts = mem[rd_ptr];
    assign next_ts = mem[rd_nxt];

    always_ff @(posedge clk) begin
        if (do_push && rst && !flush) begin
            mem[wr_ptr] <= push_ts;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_nxt;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axon_delay_queue.sv
// Axon delay stage: queues fire_ts + axon delay and presents each spike on a
// valid/ready port once global time reaches it. AXON_DROP_CNT_EN adds drop_cnt.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   ST_IDLE | queue empty, nothing presented
//   ST_WAIT | head queued but not yet due
//   ST_EMIT | head presented on spk_valid/spk_ts until taken
module axon_delay_queue
    import snn_pkg::*;
#(
    parameter int TS_W  = SNN_TS_W,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kill,
    input  logic [TS_W-1:0]  axon_delay,
    input  logic [TS_W-1:0]  t_now,
    input  logic             fire_valid,
    input  logic [TS_W-1:0]  fire_ts,
    output logic             spk_valid,
    output logic [TS_W-1:0]  spk_ts,
    input  logic             spk_ready,
    output logic [CNT_W-1:0] q_count,
    output logic             q_full,
    output logic             overflow
`ifdef AXON_DROP_CNT_EN
    ,
    output logic [TS_W-1:0]  drop_cnt
`endif
);

    logic [TS_W-1:0] delay_r;
    logic [TS_W-1:0] push_due;
    logic [TS_W-1:0] head_ts;
    logic [TS_W-1:0] next_ts;
    logic            head_due;
    logic            next_due;
    logic            q_empty;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic            more_left;
    axon_state_t     state;

    // The delay is a per-neuron constant captured only while reset is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            delay_r <= axon_delay;
        end
    end

    assign push_due  = fire_ts + delay_r;
    assign pop       = spk_valid & spk_ready;
    assign push_ok   = fire_valid & ~kill & (~q_full | pop);
    assign drop      = fire_valid & ~kill & q_full & ~pop;
    assign more_left = (q_count > CNT_W'(1));

    spike_fifo #(
        .TS_W  (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (kill),
        .push    (push_ok),
        .pop     (pop),
        .push_ts (push_due),
        .head_ts (head_ts),
        .next_ts (next_ts),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    generate
        if (TS_W == SNN_TS_W) begin : g_pkg_due
            assign head_due = ts_is_due(t_now, head_ts);
            assign next_due = ts_is_due(t_now, next_ts);
        end else begin : g_local_due
            logic [TS_W-1:0] head_age;
            logic [TS_W-1:0] next_age;
            assign head_age = t_now - head_ts;
            assign next_age = t_now - next_ts;
            assign head_due = ~head_age[TS_W-1];
            assign next_due = ~next_age[TS_W-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            spk_valid <= 1'b0;
            spk_ts    <= '0;
            overflow  <= 1'b0;
        end else if (kill) begin
            state     <= ST_IDLE;
            spk_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            overflow <= drop;
            case (state)
                ST_IDLE: begin
                    if (push_ok) begin
                        state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (q_empty) begin
                        state <= ST_IDLE;
                    end else if (head_due) begin
                        state     <= ST_EMIT;
                        spk_valid <= 1'b1;
                        spk_ts    <= head_ts;
                    end
                end
                ST_EMIT: begin
                    // Back-to-back presentation when the entry behind the head is already due.
                    if (pop) begin
                        if (more_left && next_due) begin
                            spk_ts <= next_ts;
                        end else begin
                            spk_valid <= 1'b0;
                            state     <= (more_left || push_ok) ? ST_WAIT : ST_IDLE;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    spk_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef AXON_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + TS_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_axon_delay_queue.sv
// Bench for axon_delay_queue: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference model.
module tb_axon_delay_queue;

    localparam int TS_W  = 8;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             kill;
    logic [TS_W-1:0]  axon_delay;
    logic [TS_W-1:0]  t_now;
    logic             fire_valid;
    logic [TS_W-1:0]  fire_ts;
    logic             spk_valid;
    logic [TS_W-1:0]  spk_ts;
    logic             spk_ready;
    logic [CNT_W-1:0] q_count;
    logic             q_full;
    logic             overflow;
`ifdef AXON_DROP_CNT_EN
    logic [TS_W-1:0]  drop_cnt;
`endif

    axon_delay_queue #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .kill       (kill),
        .axon_delay (axon_delay),
        .t_now      (t_now),
        .fire_valid (fire_valid),
        .fire_ts    (fire_ts),
        .spk_valid  (spk_valid),
        .spk_ts     (spk_ts),
        .spk_ready  (spk_ready),
        .q_count    (q_count),
        .q_full     (q_full),
        .overflow   (overflow)
`ifdef AXON_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pending due times in arrival order, plus the presented spike.
    int unsigned mq[$];
    bit          m_valid;
    int unsigned m_ts;
    bit          m_ovf;
    int unsigned m_delay;
    int unsigned m_drops;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_is_due(input int unsigned now, input int unsigned due);
        return ((now - due) % 256) < 128;
    endfunction

    // Applies the edge rules to the model using the inputs currently driven.
    task automatic model_edge();
        bit pop;
        bit full;
        if (!rst) begin
            mq.delete();
            m_valid = 0;
            m_ts    = 0;
            m_ovf   = 0;
            m_delay = axon_delay;
            m_drops = 0;
            return;
        end
        if (kill) begin
            mq.delete();
            m_valid = 0;
            m_ovf   = 0;
            return;
        end
        pop  = m_valid && spk_ready;
        full = (mq.size() == DEPTH);
        if (pop) begin
            void'(mq.pop_front());
            if (mq.size() > 0 && m_is_due(t_now, mq[0])) m_ts = mq[0];
            else m_valid = 0;
        end else if (!m_valid && mq.size() > 0 && m_is_due(t_now, mq[0])) begin
            m_valid = 1;
            m_ts    = mq[0];
        end
        m_ovf = fire_valid && full && !pop;
        if (fire_valid && (!full || pop)) mq.push_back((fire_ts + m_delay) % 256);
        if (m_ovf && m_drops < 255) m_drops++;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check_val("spk_valid", spk_valid, m_valid);
        if (m_valid) check_val("spk_ts", spk_ts, m_ts);
        check_val("q_count", q_count, mq.size());
        check_val("q_full", q_full, mq.size() == DEPTH);
        check_val("overflow", overflow, m_ovf);
`ifdef AXON_DROP_CNT_EN
        check_val("drop_cnt", drop_cnt, m_drops);
`endif
    endtask

    task automatic wait_valid(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && spk_valid !== 1'b1; i++) tick();
        check_val(tag, spk_valid, 1);
    endtask

    task automatic do_reset(input logic [TS_W-1:0] dly, input logic [TS_W-1:0] tn);
        rst = 0; kill = 0; fire_valid = 0; spk_ready = 0;
        axon_delay = dly; t_now = tn;
        tick();
        rst = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; kill = 0; fire_valid = 0; fire_ts = 0; spk_ready = 0;
        t_now = 10; axon_delay = 3;

        // Scenario 1: delay 3, fire at 10 -> presented once t_now reaches 13
        tick();
        tick();
        check_val("rst_spk_ts", spk_ts, 0);
        check_val("rst_q_count", q_count, 0);
        check_val("rst_valid", spk_valid, 0);
        rst = 1;
        fire_valid = 1; fire_ts = 10;
        tick();
        fire_valid = 0;
        check_val("t1_q_count", q_count, 1);
        for (int t = 11; t <= 12; t++) begin
            t_now = 8'(t);
            tick();
            check_val("t1_early", spk_valid, 0);
        end
        t_now = 13;
        tick();
        check_val("t1_valid", spk_valid, 1);
        check_val("t1_ts", spk_ts, 13);
        spk_ready = 1;
        tick();
        spk_ready = 0;
        check_val("t1_pop_count", q_count, 0);
        check_val("t1_pop_valid", spk_valid, 0);

        // Scenario 2: five fires into a depth-4 queue
        do_reset(8'd100, 8'd0);
        fire_valid = 1;
        for (int i = 0; i < 4; i++) begin
            fire_ts = 8'(i);
            tick();
        end
        check_val("t2_full", q_full, 1);
        check_val("t2_cnt", q_count, 4);
        check_val("t2_no_ovf", overflow, 0);
        fire_ts = 4;
        tick();
        fire_valid = 0;
        check_val("t2_ovf", overflow, 1);
        check_val("t2_cnt5", q_count, 4);
`ifdef AXON_DROP_CNT_EN
        check_val("t2_drop_cnt", drop_cnt, 1);
`endif
        tick();
        check_val("t2_ovf_pulse", overflow, 0);

        // Scenario 6: full queue, push and pop in the same cycle
        t_now = 103;
        wait_valid("t6_wait_valid", 10);
        check_val("t6_head", spk_ts, 100);
        fire_valid = 1; fire_ts = 50; spk_ready = 1;
        tick();
        fire_valid = 0;
        check_val("t6_cnt", q_count, 4);
        check_val("t6_no_ovf", overflow, 0);
        t_now = 160;
        for (int i = 0; i < 8; i++) tick();
        spk_ready = 0;
        check_val("t6_drained", q_count, 0);

        // Scenario 3: due time wraps past 255
        do_reset(8'd10, 8'd250);
        fire_valid = 1; fire_ts = 250;
        tick();
        fire_valid = 0;
        for (int t = 251; t <= 259; t++) begin
            t_now = 8'(t % 256);
            tick();
            check_val("t3_not_due", spk_valid, 0);
        end
        t_now = 4;
        tick();
        check_val("t3_valid", spk_valid, 1);
        check_val("t3_ts", spk_ts, 4);
        spk_ready = 1;
        tick();
        spk_ready = 0;

        // Scenario 4: backpressure holds the presented spike stable
        do_reset(8'd0, 8'd20);
        fire_valid = 1; fire_ts = 20;
        tick();
        tick();
        fire_valid = 0;
        wait_valid("t4_wait_valid", 10);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("t4_hold_valid", spk_valid, 1);
            check_val("t4_hold_ts", spk_ts, 20);
        end
        spk_ready = 1;
        tick();
        spk_ready = 0;
        check_val("t4_next_valid", spk_valid, 1);
        check_val("t4_next_cnt", q_count, 1);

        // Scenario 5: kill flushes and blocks pushes
        do_reset(8'd0, 8'd30);
        fire_valid = 1; fire_ts = 30;
        for (int i = 0; i < 3; i++) tick();
        fire_valid = 0;
        wait_valid("t5_wait_valid", 10);
        check_val("t5_cnt3", q_count, 3);
        kill = 1; fire_valid = 1;
        tick();
        check_val("t5_kill_cnt", q_count, 0);
        check_val("t5_kill_valid", spk_valid, 0);
        check_val("t5_kill_ovf", overflow, 0);
        tick();
        check_val("t5_kill_hold_cnt", q_count, 0);
        kill = 0; fire_valid = 0;
        tick();

        // Randomized traffic against the model
        do_reset(8'($urandom_range(0, 127)), 8'($urandom));
        for (int c = 0; c < 4000; c++) begin
            rst        = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
            axon_delay = 8'($urandom_range(0, 127));
            if ($urandom_range(0, 1) == 1) t_now = t_now + 8'd1;
            fire_valid = ($urandom_range(0, 2) == 0);
            fire_ts    = t_now;
            spk_ready  = ($urandom_range(0, 9) < (((c / 500) % 2 == 1) ? 2 : 8));
            kill       = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
